// File: rtl/data_mem_alt.sv
// data_mem_alt: simple dual-port synchronous RAM with one write port and one
// registered read port. After reset a sequencer sweeps every word to zero
// (busy=1) before the ports are honoured.
// Optional build macro: RDW_BYPASS_EN selects write-first behaviour on a
// same-address read/write collision; when undefined the read returns the old
// contents (read-first).
module data_mem_alt #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   clear_ptr_r;
    logic [ADDR_WIDTH-1:0]   clear_ptr_nxt_s;
    logic [DATA_WIDTH-1:0]   rd_data_r;
    logic [DATA_WIDTH-1:0]   rd_data_nxt_s;
    logic                    rd_valid_r;
    logic                    rd_valid_nxt_s;
    logic                    busy_r;
    logic                    busy_nxt_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_waddr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign busy     = busy_r;

    // Next-state, memory write port mux and read-data selection.
    always_comb begin
        state_nxt_s     = state_r;
        clear_ptr_nxt_s = clear_ptr_r;
        rd_data_nxt_s   = rd_data_r;
        rd_valid_nxt_s  = 1'b0;
        busy_nxt_s      = busy_r;
        mem_we_s        = 1'b0;
        mem_waddr_s     = wr_addr;
        mem_wdata_s     = wr_data;
        case (state_r)
            ST_CLEAR: begin
                // User ports are ignored; the sweep owns the write port.
                mem_we_s        = 1'b1;
                mem_waddr_s     = clear_ptr_r;
                mem_wdata_s     = {DATA_WIDTH{1'b0}};
                clear_ptr_nxt_s = clear_ptr_r + PTR_ONE;
                if (clear_ptr_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_CLEAR;
                    busy_nxt_s  = 1'b1;
                end
            end
            ST_IDLE: begin
                busy_nxt_s     = 1'b0;
                mem_we_s       = wr_en;
                rd_valid_nxt_s = rd_en;
                if (rd_en) begin
`ifdef RDW_BYPASS_EN
                    // Write-first: forward the incoming word on a collision.
                    if (wr_en && (wr_addr == rd_addr)) begin
                        rd_data_nxt_s = wr_data;
                    end else begin
                        rd_data_nxt_s = mem_r[rd_addr];
                    end
`else
                    // Read-first: array is sampled before this edge's write lands.
                    rd_data_nxt_s = mem_r[rd_addr];
`endif
                end else begin
                    rd_data_nxt_s = rd_data_r;
                end
            end
            default: begin
                state_nxt_s     = ST_CLEAR;
                clear_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
                busy_nxt_s      = 1'b1;
            end
        endcase
    end

    // Control and output registers with synchronous reset back into the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_CLEAR;
            clear_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_data_r   <= {DATA_WIDTH{1'b0}};
            rd_valid_r  <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            clear_ptr_r <= clear_ptr_nxt_s;
            rd_data_r   <= rd_data_nxt_s;
            rd_valid_r  <= rd_valid_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Storage array; left untouched during the reset cycle itself.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_data_mem_alt.sv
// Directed self-checking bench for data_mem_alt (DATA_WIDTH=16, ADDR_WIDTH=3).
// Honours RDW_BYPASS_EN to pick the expected collision result.
module tb_data_mem_alt;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;

    int total;
    int bad;

    data_mem_alt #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [2:0] a, input logic [15:0] exp);
        rd_en = 1'b1; rd_addr = a;
        step();
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    endtask

    initial begin
        logic [15:0] coll_exp;
        total = 0; bad = 0;
        reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
        rd_en = 1'b0; rd_addr = 3'd0;

        // Reset held two cycles.
        step(); step();
        check("rst_data", 32'(rd_data), 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);

        // Sweep: busy for exactly 8 edges; port activity ignored meanwhile.
        reset = 1'b0;
        wr_en = 1'b1; wr_data = 16'hDEAD; rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wr_addr = 3'(k); rd_addr = 3'(k);
            step();
            check($sformatf("sweep_busy%0d", k), 32'(busy), (k < 8) ? 32'h1 : 32'h0);
            check($sformatf("sweep_valid%0d", k), 32'(rd_valid), 32'h0);
            check($sformatf("sweep_data%0d", k), 32'(rd_data), 32'h0);
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // Every word reads as zero after the sweep.
        for (int a = 0; a < 8; a++) do_read($sformatf("clr_rd%0d", a), 3'(a), 16'h0000);
        rd_en = 1'b0;

        // Write/read back.
        do_write(3'd1, 16'h0001);
        do_write(3'd2, 16'h0002);
        do_write(3'd3, 16'h0003);
        do_write(3'd4, 16'h0004);
        do_read("wb1", 3'd1, 16'h0001);
        do_read("wb2", 3'd2, 16'h0002);
        do_read("wb3", 3'd3, 16'h0003);
        do_read("wb4", 3'd4, 16'h0004);

        // Hold with rd_en low.
        rd_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hold_data%0d", k), 32'(rd_data), 32'h0004);
            check($sformatf("hold_valid%0d", k), 32'(rd_valid), 32'h0);
        end

        // Independent read and write at different addresses in one cycle.
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0606;
        do_read("diff_rd", 3'd2, 16'h0002);
        rd_en = 1'b0;
        do_read("diff_wr", 3'd6, 16'h0606);

        // Same-address collision.
        rd_en = 1'b0;
        do_write(3'd5, 16'hAAAA);
`ifdef RDW_BYPASS_EN
        coll_exp = 16'h5555;
`else
        coll_exp = 16'hAAAA;
`endif
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
        do_read("coll", 3'd5, coll_exp);
        wr_en = 1'b0;
        do_read("coll_after", 3'd5, 16'h5555);
        rd_en = 1'b0;

        // Reset mid-operation.
        do_write(3'd7, 16'hBEEF);
        reset = 1'b1;
        step();
        check("mid_rst_data", 32'(rd_data), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1111;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("mid_busy%0d", k), 32'(busy), (k < 8) ? 32'h1 : 32'h0);
        end
        wr_en = 1'b0;
        do_read("mid_rd7", 3'd7, 16'h0000);
        do_read("mid_rd5", 3'd5, 16'h0000);
        rd_en = 1'b0;

        // Wrap across the top address.
        do_write(3'd7, 16'hFFFF);
        do_write(3'd0, 16'h1234);
        do_read("wrap7", 3'd7, 16'hFFFF);
        do_read("wrap0", 3'd0, 16'h1234);
        rd_en = 1'b0;
        step();
        check("final_valid", 32'(rd_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
